solomon_sndcmd: RTL and testbench
=================================

SOLOMON_SNDCMD -- requirements
Module: solomon_sndcmd

Interface
REQ-001: Parameter DEPTH, default 4, command FIFO depth in entries; SHALL be a power of two from 2 to 16.
REQ-002: Parameter NMI_GAP, default 8, number of MCLK cycles SNMI_N SHALL stay high between consecutive NMI assertions.
REQ-003: MCLK  in  1  48 MHz system clock; the single clock; all state SHALL change on its rising edge.
REQ-004: RESET  in  1  asynchronous, active-high reset.
REQ-005: SNDWR  in  1  main-CPU sound-command write strobe, level, may stay high for many MCLK cycles.
REQ-006: SNDNO  in  8  command byte, valid while SNDWR is high.
REQ-007: SNDT  in  1  periodic timer tick from the video timing, level.
REQ-008: SRD  in  1  sound-CPU command-latch read strobe, level.
REQ-009: SIACK  in  1  sound-CPU interrupt acknowledge, level.
REQ-010: NMIEN_WR  in  1  NMI-enable register write strobe, sampled on rising edge of MCLK while high.
REQ-011: NMIEN_D  in  1  NMI-enable value written by NMIEN_WR.
REQ-012: SDOUT  out  8  FIFO head byte presented to the sound CPU.
REQ-013: SNMI_N  out  1  active-low NMI to the sound CPU.
REQ-014: SIRQ_N  out  1  active-low maskable IRQ to the sound CPU.
REQ-015: EMPTY  out  1  FIFO holds no entries.
REQ-016: FULL  out  1  FIFO holds DEPTH entries.
REQ-017: OVF  out  1  sticky overflow flag.

Function
REQ-018: Push SHALL occur on an MCLK edge where SNDWR=1 and its registered copy=0, i.e. exactly one push per SNDWR pulse regardless of pulse length.
REQ-019: Pop SHALL occur on an MCLK edge where SRD=0 and its registered copy=1; data is therefore stable on SDOUT for the entire read strobe.
REQ-020: SDOUT SHALL be combinationally the entry at the read pointer when not EMPTY; when EMPTY it SHALL hold the last popped byte.
REQ-021: Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH; occupancy count SHALL be log2(DEPTH)+1 bits.
REQ-022: Push when FULL without simultaneous pop: byte dropped, state unchanged except OVF set to 1; OVF cleared only by RESET.
REQ-023: Pop when EMPTY: ignored, no pointer change, no flag change.
REQ-024: Simultaneous push and pop: both performed, occupancy unchanged; when FULL, the push is accepted (no OVF); when EMPTY, the pop is ignored and the push is accepted.
REQ-025: EMPTY and FULL SHALL be registered and reflect occupancy after the same edge that changes it.
REQ-026: NMI FSM states: IDLE (SNMI_N=1), ASSERT (SNMI_N=0), GAP (SNMI_N=1); SNMI_N SHALL be a registered output.
REQ-027: IDLE->ASSERT when NMI enable=1 and EMPTY=0; SNMI_N falls one MCLK cycle after EMPTY falls.
REQ-028: ASSERT->GAP on a pop edge; GAP SHALL last exactly NMI_GAP cycles, then ->ASSERT if enable=1 and not EMPTY, else ->IDLE.
REQ-029: Enable written to 0 in any state SHALL force the FSM to IDLE on that edge, SNMI_N=1 the following cycle.
REQ-030: IRQ pending SHALL be set on the rising edge of SNDT (registered edge detect) and cleared on the rising edge of SIACK; SIRQ_N = NOT pending.
REQ-031: Coincident SNDT and SIACK rising edges: pending SHALL remain set.

Reset
REQ-032: While RESET=1: pointers, count, OVF=0; EMPTY=1; FULL=0; SDOUT=0x00; NMI enable=0; FSM=IDLE; SNMI_N=1; SIRQ_N=1; edge-detect registers=0.
REQ-033: A strobe already high when RESET is released SHALL NOT produce a push, pop, or IRQ edge.
REQ-034: RESET asserted mid-operation SHALL discard all FIFO contents and pending interrupts immediately, without waiting for MCLK.

Verification
REQ-035: Enable NMI; SNDWR high 12 cycles with SNDNO=0x5A -> one push, SDOUT=0x5A, EMPTY 1->0, SNMI_N low one cycle after EMPTY falls.
REQ-036: Push 0x01..0x05 with DEPTH=4 -> FULL=1 after 4th, 5th dropped, OVF=1; pops return 0x01..0x04, then EMPTY=1, SDOUT holds 0x04.
REQ-037: Two entries queued, NMI enabled; pop -> SNMI_N high exactly 8 cycles, then low again; second pop -> SNMI_N high and stays high (IDLE).
REQ-038: FIFO full; push and pop on same edge -> occupancy 4, OVF=0, FIFO order preserved.
REQ-039: SNDT rise -> SIRQ_N=0; SIACK rise coincident with next SNDT rise -> SIRQ_N stays 0; lone SIACK rise -> SIRQ_N=1.
REQ-040: RESET pulsed with 3 entries, SIRQ_N=0 and SNDWR held high -> all outputs at reset values; SNDWR release/re-raise -> exactly one push.

Source files
------------

// File: rtl/solomon_sndcmd.sv
// Sound-command latch between the main and sound CPUs: a byte FIFO with an
// NMI pacing FSM and a timer-driven maskable IRQ.
module solomon_sndcmd #(
    parameter int DEPTH   = 4,
    parameter int NMI_GAP = 8
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       SNDWR,
    input  logic [7:0] SNDNO,
    input  logic       SNDT,
    input  logic       SRD,
    input  logic       SIACK,
    input  logic       NMIEN_WR,
    input  logic       NMIEN_D,
    output logic [7:0] SDOUT,
    output logic       SNMI_N,
    output logic       SIRQ_N,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(NMI_GAP + 1);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;
    localparam logic [GW-1:0] GAP_ONE  = 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(NMI_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

    logic          arm_q;
    logic          sndwr_q, srd_q, sndt_q, siack_q;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty_q, full_q, ovf_q, ovf_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    mem_q [DEPTH];
    logic          nmien_q, nmien_d;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          snmi_n_q;
    logic          pend_q, pend_d;

    logic push, pop, do_push, do_pop, trise, arise;

    // arm_q masks the first edge after reset so held strobes are not edges
    assign push    = arm_q & SNDWR & ~sndwr_q;
    assign pop     = arm_q & ~SRD & srd_q;
    assign trise   = arm_q & SNDT & ~sndt_q;
    assign arise   = arm_q & SIACK & ~siack_q;
    assign do_pop  = pop & ~empty_q;
    assign do_push = push & (~full_q | do_pop);

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        ovf_d  = ovf_q | (push & full_q & ~do_pop);
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop) begin
            rd_d   = rd_q + PTR_ONE;
            last_d = mem_q[rd_q];
        end
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
        else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        nmien_d = NMIEN_WR ? NMIEN_D : nmien_q;
        unique case (state_q)
            S_IDLE:   if (nmien_q && !empty_q) state_d = S_ASSERT;
            S_ASSERT: if (do_pop) begin
                state_d = S_GAP;
                gap_d   = GAP_INIT;
            end
            S_GAP: begin
                if (gap_q == '0)
                    state_d = (nmien_q && !empty_q) ? S_ASSERT : S_IDLE;
                else
                    gap_d = gap_q - GAP_ONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (NMIEN_WR && !NMIEN_D) state_d = S_IDLE;
    end

    // a timer tick wins over a coincident acknowledge
    assign pend_d = trise | (pend_q & ~arise);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            arm_q    <= 1'b0;
            sndwr_q  <= 1'b0;
            srd_q    <= 1'b0;
            sndt_q   <= 1'b0;
            siack_q  <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            last_q   <= 8'h00;
            nmien_q  <= 1'b0;
            state_q  <= S_IDLE;
            gap_q    <= '0;
            snmi_n_q <= 1'b1;
            pend_q   <= 1'b0;
        end else begin
            arm_q    <= 1'b1;
            sndwr_q  <= SNDWR;
            srd_q    <= SRD;
            sndt_q   <= SNDT;
            siack_q  <= SIACK;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == '0);
            full_q   <= (cnt_d == CNT_FULL);
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            nmien_q  <= nmien_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            snmi_n_q <= (state_d != S_ASSERT);
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge MCLK) begin
        if (do_push) mem_q[wr_q] <= SNDNO;
    end

    assign SDOUT  = empty_q ? last_q : mem_q[rd_q];
    assign SNMI_N = snmi_n_q;
    assign SIRQ_N = ~pend_q;
    assign EMPTY  = empty_q;
    assign FULL   = full_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_solomon_sndcmd.sv
// Directed bench for solomon_sndcmd: FIFO order/overflow, NMI pacing,
// IRQ edge handling and asynchronous reset behaviour.
module tb_solomon_sndcmd;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SNDWR = 1'b0;
    logic [7:0] SNDNO = 8'h00;
    logic       SNDT = 1'b0;
    logic       SRD = 1'b0;
    logic       SIACK = 1'b0;
    logic       NMIEN_WR = 1'b0;
    logic       NMIEN_D = 1'b0;
    logic [7:0] SDOUT;
    logic       SNMI_N, SIRQ_N, EMPTY, FULL, OVF;

    int vectors = 0;
    int miscompares = 0;

    solomon_sndcmd #(.DEPTH(4), .NMI_GAP(8)) dut (
        .MCLK(MCLK), .RESET(RESET), .SNDWR(SNDWR), .SNDNO(SNDNO),
        .SNDT(SNDT), .SRD(SRD), .SIACK(SIACK),
        .NMIEN_WR(NMIEN_WR), .NMIEN_D(NMIEN_D),
        .SDOUT(SDOUT), .SNMI_N(SNMI_N), .SIRQ_N(SIRQ_N),
        .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF)
    );

    always #5 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        SNDWR = 1'b1;
        SNDNO = b;
        tick();
        SNDWR = 1'b0;
        tick();
    endtask

    task automatic pop();
        SRD = 1'b1;
        tick();
        SRD = 1'b0;
        tick();
    endtask

    task automatic nmien(input logic v);
        NMIEN_WR = 1'b1;
        NMIEN_D  = v;
        tick();
        NMIEN_WR = 1'b0;
    endtask

    initial begin
        // reset values while RESET is held
        tick();
        chk("rst_sdout", SDOUT, 8'h00);
        chk("rst_empty", {7'd0, EMPTY}, 8'd1);
        chk("rst_full", {7'd0, FULL}, 8'd0);
        chk("rst_ovf", {7'd0, OVF}, 8'd0);
        chk("rst_snmi", {7'd0, SNMI_N}, 8'd1);
        chk("rst_sirq", {7'd0, SIRQ_N}, 8'd1);
        RESET = 1'b0;
        tick();

        // long write strobe gives one push; NMI follows EMPTY by a cycle
        nmien(1'b1);
        SNDWR = 1'b1;
        SNDNO = 8'h5A;
        tick();
        chk("long_empty", {7'd0, EMPTY}, 8'd0);
        chk("long_sdout", SDOUT, 8'h5A);
        chk("long_nmi_pre", {7'd0, SNMI_N}, 8'd1);
        tick();
        chk("long_nmi_low", {7'd0, SNMI_N}, 8'd0);
        for (int i = 0; i < 10; i++) tick();
        SNDWR = 1'b0;
        tick();
        pop();
        chk("long_one_push", {7'd0, EMPTY}, 8'd1);
        chk("long_sdout_hold", SDOUT, 8'h5A);

        // fill, overflow, drain in order
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
            if (i == 4) chk("fill_full4", {7'd0, FULL}, 8'd1);
            if (i == 4) chk("fill_ovf4", {7'd0, OVF}, 8'd0);
        end
        chk("ovf_set", {7'd0, OVF}, 8'd1);
        chk("ovf_full", {7'd0, FULL}, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_head", SDOUT, 8'(i));
            pop();
        end
        chk("drain_empty", {7'd0, EMPTY}, 8'd1);
        chk("drain_last", SDOUT, 8'h04);
        chk("drain_ovf_sticky", {7'd0, OVF}, 8'd1);
        pop();
        chk("pop_empty_ignored", SDOUT, 8'h04);

        // push and pop on the same edge while full
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        SRD = 1'b1;
        tick();
        SRD = 1'b0;
        SNDWR = 1'b1;
        SNDNO = 8'h55;
        tick();
        SNDWR = 1'b0;
        chk("pp_full", {7'd0, FULL}, 8'd1);
        chk("pp_ovf", {7'd0, OVF}, 8'd0);
        chk("pp_head", SDOUT, 8'h02);
        tick();
        pop();
        chk("pp_ord3", SDOUT, 8'h03);
        pop();
        chk("pp_ord4", SDOUT, 8'h04);
        pop();
        chk("pp_ord55", SDOUT, 8'h55);
        pop();
        chk("pp_empty", {7'd0, EMPTY}, 8'd1);

        // NMI gap timing
        do_reset();
        nmien(1'b1);
        push(8'hA1);
        push(8'hB2);
        chk("gap_assert", {7'd0, SNMI_N}, 8'd0);
        pop();
        chk("gap_hi0", {7'd0, SNMI_N}, 8'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("gap_hi", {7'd0, SNMI_N}, 8'd1);
        end
        tick();
        chk("gap_relow", {7'd0, SNMI_N}, 8'd0);
        chk("gap_head", SDOUT, 8'hB2);
        pop();
        for (int i = 0; i < 12; i++) tick();
        chk("gap_idle", {7'd0, SNMI_N}, 8'd1);
        chk("gap_empty", {7'd0, EMPTY}, 8'd1);

        // enable cleared while asserted forces idle
        push(8'hC3);
        chk("dis_pre", {7'd0, SNMI_N}, 8'd0);
        nmien(1'b0);
        chk("dis_idle", {7'd0, SNMI_N}, 8'd1);

        // IRQ set / coincident ack / lone ack
        SNDT = 1'b1;
        tick();
        chk("irq_set", {7'd0, SIRQ_N}, 8'd0);
        SNDT = 1'b0;
        tick();
        SNDT = 1'b1;
        SIACK = 1'b1;
        tick();
        chk("irq_coinc", {7'd0, SIRQ_N}, 8'd0);
        SNDT = 1'b0;
        SIACK = 1'b0;
        tick();
        SIACK = 1'b1;
        tick();
        chk("irq_ack", {7'd0, SIRQ_N}, 8'd1);
        SIACK = 1'b0;
        tick();

        // asynchronous reset mid-operation with SNDWR held
        do_reset();
        push(8'h11);
        push(8'h22);
        SNDT = 1'b1;
        tick();
        SNDT = 1'b0;
        SNDWR = 1'b1;
        SNDNO = 8'h33;
        tick();
        chk("ar_pre_irq", {7'd0, SIRQ_N}, 8'd0);
        chk("ar_pre_empty", {7'd0, EMPTY}, 8'd0);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_empty", {7'd0, EMPTY}, 8'd1);
        chk("ar_sdout", SDOUT, 8'h00);
        chk("ar_sirq", {7'd0, SIRQ_N}, 8'd1);
        chk("ar_full", {7'd0, FULL}, 8'd0);
        chk("ar_snmi", {7'd0, SNMI_N}, 8'd1);
        tick();
        RESET = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_held_nopush", {7'd0, EMPTY}, 8'd1);
        SNDWR = 1'b0;
        tick();
        SNDWR = 1'b1;
        SNDNO = 8'h99;
        tick();
        chk("ar_repush", SDOUT, 8'h99);
        tick();
        tick();
        SNDWR = 1'b0;
        tick();
        pop();
        chk("ar_one_push", {7'd0, EMPTY}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
